// File: rtl/exec_pkg.sv
// Shared types for the RV32IM execute stage: ALU/M-extension op encodings,
// execute FSM states and divider counter sizing.
package exec_pkg;

    localparam int unsigned EXEC_DATA_WIDTH = 32;
    localparam int unsigned DIV_CNT_W       = $clog2(EXEC_DATA_WIDTH);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/div_iter.sv
// Restoring iterative divider: one quotient bit per cycle on operand
// magnitudes, signs and the divide-by-zero/overflow cases fixed at the output.
module div_iter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          DIV_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    if (DIV_EN) begin : g_div
        localparam int unsigned CW = $clog2(DATA_WIDTH);

        logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, dvd_q, dvd_d;
        logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
        logic                  dvz_q, dvz_d, ovf_q, ovf_d;
        logic                  busy_q, busy_d, done_q, done_d;
        logic [CW-1:0]         cnt_q, cnt_d;
        logic [DATA_WIDTH:0]   rem_shift, rem_sub;
        logic                  a_neg, b_neg;

        always_comb begin
            rem_d     = rem_q;
            quo_d     = quo_q;
            dsr_d     = dsr_q;
            dvd_d     = dvd_q;
            neg_quo_d = neg_quo_q;
            neg_rem_d = neg_rem_q;
            dvz_d     = dvz_q;
            ovf_d     = ovf_q;
            busy_d    = busy_q;
            done_d    = done_q;
            cnt_d     = cnt_q;
            a_neg     = is_signed & dividend[DATA_WIDTH-1];
            b_neg     = is_signed & divisor[DATA_WIDTH-1];
            // Quotient register doubles as the dividend shift register.
            rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
            rem_sub   = rem_shift - {1'b0, dsr_q};

            if (abort) begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end else if (start) begin
                dvd_d     = dividend;
                rem_d     = '0;
                quo_d     = a_neg ? -dividend : dividend;
                dsr_d     = b_neg ? -divisor : divisor;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dvz_d     = (divisor == '0);
                ovf_d     = is_signed && (dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                            && (divisor == '1);
                busy_d    = 1'b1;
                done_d    = 1'b0;
                cnt_d     = '0;
            end else if (busy_q) begin
                if (!rem_sub[DATA_WIDTH]) begin
                    rem_d = rem_sub[DATA_WIDTH-1:0];
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[DATA_WIDTH-1:0];
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH-1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem_q     <= '0;
                quo_q     <= '0;
                dsr_q     <= '0;
                dvd_q     <= '0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
                dvz_q     <= 1'b0;
                ovf_q     <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                cnt_q     <= '0;
            end else begin
                rem_q     <= rem_d;
                quo_q     <= quo_d;
                dsr_q     <= dsr_d;
                dvd_q     <= dvd_d;
                neg_quo_q <= neg_quo_d;
                neg_rem_q <= neg_rem_d;
                dvz_q     <= dvz_d;
                ovf_q     <= ovf_d;
                busy_q    <= busy_d;
                done_q    <= done_d;
                cnt_q     <= cnt_d;
            end
        end

        assign done      = done_q;
        assign quotient  = dvz_q ? '1 : (ovf_q ? dvd_q : (neg_quo_q ? -quo_q : quo_q));
        assign remainder = dvz_q ? dvd_q : (ovf_q ? '0 : (neg_rem_q ? -rem_q : rem_q));
    end else begin : g_tie
        assign done      = 1'b1;
        assign quotient  = '1;
        assign remainder = '1;
    end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: MEM/WB forwarding, single-cycle ALU/compare/multiply,
// multi-cycle divide with upstream stall, registered EX/MEM outputs.
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = EXEC_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter bit          DIV_EN        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [ADDRESS_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDRESS_WIDTH-1:0] id_rd_addr,
    input  logic [3:0]               id_alu_ctrl,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_md_en,
    input  logic [2:0]               id_md_op,
    input  logic                     mem_reg_write,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic                     wb_reg_write,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     stall_o,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic [ADDRESS_WIDTH-1:0] ex_rd_addr,
    output logic [DATA_WIDTH-1:0]    ex_result,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_eq,
    output logic                     ex_lt,
    output logic                     ex_ltu
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   rs1_fwd, rs2_fwd, op_b, alu_res, md_res, exec_res;
    logic [2*DATA_WIDTH-1:0] mul_a, mul_b, prod;
    logic [CNT_W-1:0]        shamt;
    logic                    is_div, a_s, b_s, cmp_eq, cmp_lt, cmp_ltu;
    logic                    div_start, div_done;
    logic [DATA_WIDTH-1:0]   div_quo, div_rem;

    ex_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] div_rd_q, div_rd_d;
    logic                     div_rw_q, div_rw_d, div_is_rem_q, div_is_rem_d;

    logic                     ex_valid_q, ex_valid_d, ex_reg_write_q, ex_reg_write_d;
    logic [ADDRESS_WIDTH-1:0] ex_rd_addr_q, ex_rd_addr_d;
    logic [DATA_WIDTH-1:0]    ex_result_q, ex_result_d, ex_store_data_q, ex_store_data_d;
    logic                     ex_eq_q, ex_eq_d, ex_lt_q, ex_lt_d, ex_ltu_q, ex_ltu_d;

    always_comb begin
        rs1_fwd = id_rs1_data;
        if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == id_rs1_addr)
            rs1_fwd = mem_result;
        else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == id_rs1_addr)
            rs1_fwd = wb_result;
        rs2_fwd = id_rs2_data;
        if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == id_rs2_addr)
            rs2_fwd = mem_result;
        else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == id_rs2_addr)
            rs2_fwd = wb_result;
    end

    assign op_b    = id_alu_src ? id_imm : rs2_fwd;
    assign shamt   = op_b[CNT_W-1:0];
    assign cmp_eq  = (rs1_fwd == rs2_fwd);
    assign cmp_lt  = ($signed(rs1_fwd) < $signed(rs2_fwd));
    assign cmp_ltu = (rs1_fwd < rs2_fwd);

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_e'(id_alu_ctrl))
            ALU_ADD:   alu_res = rs1_fwd + op_b;
            ALU_SUB:   alu_res = rs1_fwd - op_b;
            ALU_AND:   alu_res = rs1_fwd & op_b;
            ALU_OR:    alu_res = rs1_fwd | op_b;
            ALU_XOR:   alu_res = rs1_fwd ^ op_b;
            ALU_SLL:   alu_res = rs1_fwd << shamt;
            ALU_SRL:   alu_res = rs1_fwd >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(rs1_fwd) >>> shamt);
            ALU_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_fwd) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, rs1_fwd < op_b};
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    // Operands sign/zero-extended to 2*W, so the low 2*W product bits are exact.
    assign a_s   = (id_md_op == MD_MULH) || (id_md_op == MD_MULHSU);
    assign b_s   = (id_md_op == MD_MULH);
    assign mul_a = {{DATA_WIDTH{a_s & rs1_fwd[DATA_WIDTH-1]}}, rs1_fwd};
    assign mul_b = {{DATA_WIDTH{b_s & op_b[DATA_WIDTH-1]}}, op_b};
    assign prod  = mul_a * mul_b;

    assign md_res   = (id_md_op[2])           ? '1 :
                      (id_md_op == MD_MUL)    ? prod[DATA_WIDTH-1:0] :
                                                prod[2*DATA_WIDTH-1:DATA_WIDTH];
    assign exec_res = id_md_en ? md_res : alu_res;
    assign is_div   = id_md_en & id_md_op[2] & DIV_EN;

    div_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_EN     (DIV_EN)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .is_signed (~id_md_op[0]),
        .dividend  (rs1_fwd),
        .divisor   (op_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        div_rd_d        = div_rd_q;
        div_rw_d        = div_rw_q;
        div_is_rem_d    = div_is_rem_q;
        div_start       = 1'b0;
        ex_valid_d      = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_rd_addr_d    = id_rd_addr;
        ex_result_d     = exec_res;
        ex_store_data_d = rs2_fwd;
        ex_eq_d         = cmp_eq;
        ex_lt_d         = cmp_lt;
        ex_ltu_d        = cmp_ltu;

        case (state_q)
            IDLE: begin
                if (id_valid && !flush) begin
                    if (is_div) begin
                        state_d      = DIV;
                        cnt_d        = '0;
                        div_start    = 1'b1;
                        div_rd_d     = id_rd_addr;
                        div_rw_d     = id_reg_write;
                        div_is_rem_d = id_md_op[1];
                    end else begin
                        ex_valid_d     = 1'b1;
                        ex_reg_write_d = id_reg_write;
                    end
                end
            end
            DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH-1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (div_done) begin
                    ex_valid_d     = 1'b1;
                    ex_reg_write_d = div_rw_q;
                    ex_rd_addr_d   = div_rd_q;
                    ex_result_d    = div_is_rem_q ? div_rem : div_quo;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d        = IDLE;
            cnt_d          = '0;
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
        end
    end

    assign stall_o = ((state_q == IDLE && id_valid && is_div) || state_q == DIV) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            div_rd_q        <= '0;
            div_rw_q        <= 1'b0;
            div_is_rem_q    <= 1'b0;
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_rd_addr_q    <= '0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_eq_q         <= 1'b0;
            ex_lt_q         <= 1'b0;
            ex_ltu_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            div_rd_q        <= div_rd_d;
            div_rw_q        <= div_rw_d;
            div_is_rem_q    <= div_is_rem_d;
            ex_valid_q      <= ex_valid_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_rd_addr_q    <= ex_rd_addr_d;
            ex_result_q     <= ex_result_d;
            ex_store_data_q <= ex_store_data_d;
            ex_eq_q         <= ex_eq_d;
            ex_lt_q         <= ex_lt_d;
            ex_ltu_q        <= ex_ltu_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_rd_addr    = ex_rd_addr_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_eq         = ex_eq_q;
    assign ex_lt         = ex_lt_q;
    assign ex_ltu        = ex_ltu_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU/MUL results, divide
// latency/stall profile, divide corner cases, flush and mid-divide reset.
module tb_execute_stage;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_md_en;
    logic [2:0]  id_md_op;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic        stall_o, ex_valid, ex_reg_write, ex_eq, ex_lt, ex_ltu;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result, ex_store_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (5),
        .DIV_EN        (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_md_en      (id_md_en),
        .id_md_op      (id_md_op),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .stall_o       (stall_o),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_rd_addr    (ex_rd_addr),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_eq         (ex_eq),
        .ex_lt         (ex_lt),
        .ex_ltu        (ex_ltu)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                             input logic src, input logic [31:0] imm);
        id_valid    = 1'b1;
        id_md_en    = 1'b0;
        id_alu_ctrl = ctrl;
        id_rs1_data = a;
        id_rs2_data = b;
        id_alu_src  = src;
        id_imm      = imm;
        step();
    endtask

    task automatic issue_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        id_valid    = 1'b1;
        id_md_en    = 1'b1;
        id_md_op    = op;
        id_rs1_data = a;
        id_rs2_data = b;
        id_alu_src  = 1'b0;
        step();
    endtask

    // Upstream model: holds the op while stall_o is high, then retires it.
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
        int          first;
        int          stalls;
        logic [31:0] res;
        logic [4:0]  rd;
        id_valid = 1'b0;
        step();
        id_valid    = 1'b1;
        id_md_en    = 1'b1;
        id_md_op    = op;
        id_rs1_data = a;
        id_rs2_data = b;
        id_alu_src  = 1'b0;
        id_rd_addr  = 5'd9;
        #1;
        first  = -1;
        stalls = 0;
        res    = '0;
        rd     = '0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0 && ex_valid) begin
                first = k;
                res   = ex_result;
                rd    = ex_rd_addr;
                break;
            end
            if (stall_o) stalls++;
            if (k == 1) id_rs1_data = 32'h5A5A_0F0F;
            if (!stall_o) id_valid = 1'b0;
            step();
        end
        id_valid   = 1'b0;
        id_rd_addr = 5'd3;
        check({tag, "_stall_cycles"}, stalls, 32'd33);
        check({tag, "_latency"}, first, 32'd34);
        check({tag, "_result"}, res, exp);
        check({tag, "_rd"}, {27'd0, rd}, 32'd9);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd3;
        id_alu_ctrl = ALU_ADD; id_alu_src = 1'b0; id_reg_write = 1'b1;
        id_md_en = 1'b0; id_md_op = MD_MUL;
        mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
        wb_reg_write = 1'b0; wb_rd_addr = '0; wb_result = '0;
        repeat (2) step();
        check("rst_valid", ex_valid, 0);
        check("rst_result", ex_result, 0);
        check("rst_regwrite", ex_reg_write, 0);
        check("rst_stall", stall_o, 0);
        rst_n = 1'b1;
        step();

        issue_alu(ALU_ADD, 32'd5, 32'd7, 1'b0, '0);
        check("add_result", ex_result, 32'd12);
        check("add_valid", ex_valid, 1);
        check("add_regwrite", ex_reg_write, 1);
        check("add_rd", ex_rd_addr, 32'd3);

        mem_reg_write = 1'b1; mem_rd_addr = 5'd1; mem_result = 32'd100;
        wb_reg_write  = 1'b1; wb_rd_addr  = 5'd1; wb_result  = 32'd200;
        issue_alu(ALU_ADD, 32'd5, 32'd7, 1'b0, '0);
        check("fwd_mem_wins", ex_result, 32'd107);
        check("fwd_store_data", ex_store_data, 32'd7);
        mem_reg_write = 1'b0;
        issue_alu(ALU_ADD, 32'd5, 32'd7, 1'b0, '0);
        check("fwd_wb", ex_result, 32'd207);
        wb_reg_write = 1'b0;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd0; id_rs1_addr = 5'd0;
        issue_alu(ALU_ADD, 32'd5, 32'd7, 1'b0, '0);
        check("fwd_rd0_blocked", ex_result, 32'd12);
        mem_reg_write = 1'b0; id_rs1_addr = 5'd1;

        issue_alu(ALU_SRA, 32'h8000_0000, 32'd0, 1'b1, 32'd4);
        check("sra", ex_result, 32'hF800_0000);
        issue_alu(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, '0);
        check("sltu", ex_result, 32'd1);
        check("cmp_ltu", ex_ltu, 1);
        check("cmp_lt", ex_lt, 0);
        check("cmp_eq_ne", ex_eq, 0);
        issue_alu(ALU_SLT, 32'd5, 32'd5, 1'b0, '0);
        check("slt_same", ex_result, 32'd0);
        check("cmp_eq", ex_eq, 1);

        issue_mul(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu", ex_result, 32'hFFFF_FFFE);
        issue_mul(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_low", ex_result, 32'd1);
        issue_mul(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulh", ex_result, 32'd0);
        issue_mul(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhsu", ex_result, 32'hFFFF_FFFF);

        id_valid = 1'b0;
        step();
        check("bubble_valid", ex_valid, 0);

        run_div(MD_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_neg");
        run_div(MD_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_neg");
        run_div(MD_DIVU, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, "divu_zero");
        run_div(MD_REM,  32'hFFFF_FF00, 32'd0,        32'hFFFF_FF00, "rem_zero");
        run_div(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_div(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "rem_ovf");

        id_valid = 1'b1; id_md_en = 1'b1; id_md_op = MD_DIV;
        id_rs1_data = 32'd100; id_rs2_data = 32'd3;
        step();
        repeat (9) step();
        check("flush_pre_stall", stall_o, 1);
        flush = 1'b1;
        #1;
        check("flush_stall_drop", stall_o, 0);
        id_valid = 1'b0;
        step();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ex_valid) seen++;
            step();
        end
        check("flush_no_result", seen, 0);
        issue_alu(ALU_ADD, 32'd5, 32'd7, 1'b0, '0);
        check("post_flush_add", ex_result, 32'd12);
        check("post_flush_valid", ex_valid, 1);

        id_valid = 1'b1; id_md_en = 1'b1; id_md_op = MD_DIVU;
        id_rs1_data = 32'd1000; id_rs2_data = 32'd7;
        repeat (5) step();
        rst_n = 1'b0;
        id_valid = 1'b0;
        #1;
        check("midrst_valid", ex_valid, 0);
        check("midrst_result", ex_result, 0);
        check("midrst_rd", ex_rd_addr, 0);
        check("midrst_stall", stall_o, 0);
        repeat (2) step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ex_valid) seen++;
            step();
        end
        check("midrst_no_partial", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Parametrised RV32IM execute stage that replaces the single-cycle register-file-plus-ALU execute block. It takes decoded operands from the ID/EX register and resolves data hazards by forwarding from MEM and WB. It executes ALU, compare and multiply ops in one cycle and divide/remainder ops over a multi-cycle iterative divider that stalls upstream. All results are registered into the EX/MEM output register.

## Interface
- DATA_WIDTH, 32, operand/result width (even, ≥8)
- ADDRESS_WIDTH, 5, register index width
- DIV_EN, 1, 0 removes the divider; div ops then return all-ones
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill current/pending op (branch mispredict)
- id_valid  in  1  ID/EX slot holds an instruction
- id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH  register-file operands, sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  ADDRESS_WIDTH  source/destination indices
- id_alu_ctrl  in  4  ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,PASSB
- id_alu_src  in  1  0: op B = forwarded rs2; 1: op B = id_imm
- id_reg_write  in  1  instruction writes rd
- id_md_en, id_md_op  in  1, 3  M-extension select; MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
- mem_reg_write, mem_rd_addr, mem_result  in  1, ADDRESS_WIDTH, DATA_WIDTH  MEM-stage forward source
- wb_reg_write, wb_rd_addr, wb_result  in  1, ADDRESS_WIDTH, DATA_WIDTH  WB-stage forward source
- stall_o  out  1  hold ID/EX and earlier stages
- ex_valid, ex_reg_write, ex_rd_addr  out  1, 1, ADDRESS_WIDTH  registered
- ex_result, ex_store_data  out  DATA_WIDTH  registered result; forwarded rs2
- ex_eq, ex_lt, ex_ltu  out  1  registered rs1-vs-rs2 compares (forwarded values)

## Operation
- Forwarding per source: MEM match (reg_write, rd≠0, rd==rsN) wins over WB match, else id data. Index 0 is never forwarded.
- Op A = fwd rs1; op B per id_alu_src. Shift amount = op B[log2(DATA_WIDTH)-1:0]. SLT signed, SLTU unsigned, result zero-extended 0/1.
- MUL* is single-cycle full 2·DATA_WIDTH product; MUL returns the low half, others the high half with stated signedness.
- DIV/REM is a restoring iterative divider, one quotient bit per cycle, on magnitudes; sign fixed at completion.
- Divide by zero: quotient all-ones, remainder = dividend.
- Signed overflow (most-negative / −1): quotient = dividend, remainder 0.
- FSM states: IDLE, DIV, DONE.
  - IDLE: id_valid & div op & !flush → latch forwarded operands, go DIV, counter = 0.
  - DIV: counter increments each cycle; at counter==DATA_WIDTH−1 go DONE.
  - DONE: write result to EX/MEM, go IDLE; id_* ignored this cycle (same instruction, released).
- stall_o = (IDLE & id_valid & div op | DIV) & !flush. DONE drives stall_o=0.
- Non-div op in IDLE with id_valid: EX/MEM loads next edge, ex_valid=1. id_valid=0: ex_valid=0.
- flush: next edge ex_valid=0, ex_reg_write=0, FSM→IDLE, divider aborted; flush beats all.
- ex_reg_write = id_reg_write & valid. ex_rd_addr is passed through unchanged.

## Timing
- Reset: FSM IDLE, counter 0. All ex_* outputs 0, stall_o 0.
- ALU/MUL latency: 1 cycle (result at edge after issue). Throughput: 1/cycle.
- DIV/REM issued cycle T: stall_o=1 in T..T+DATA_WIDTH. DONE in T+DATA_WIDTH+1. ex_valid=1 with result after the edge ending T+DATA_WIDTH+1.
- ex_valid=0 (bubble) throughout DIV.
- Operands are latched at T; later MEM/WB changes do not affect the divide.
- rst_n asserted mid-divide: immediate return to reset state; no partial result emitted.
- Forward muxes and compares are combinational from inputs; no combinational path from inputs to ex_* outputs.

## Structure
- Package exec_pkg holds:
  - alu_ctrl_e (4-bit) and md_op_e (3-bit) enums
  - ex_state_e {IDLE, DIV, DONE}
  - localparam for the divide counter width, $clog2(DATA_WIDTH)
- Sub-module div_iter holds the iterative divider:
  - inputs: start, abort, signed, operands
  - outputs: done, quotient, remainder
  - DIV_EN=0 ties it off.
- Forwarding, ALU, multiplier and EX/MEM register stay in execute_stage.

## Test plan
- Reset, then ADD with rs1=5, rs2=7, no forwarding → ex_result=12, ex_valid=1 one cycle later. Repeat with rs1 fed by mem_result=100 (rd match) and also wb_result=200 → 107 (MEM wins). rd=0 match → no forward.
- SRA with 0x8000_0000 by 4 → 0xF800_0000. SLTU 1 vs 0xFFFF_FFFF → 1. SLT same → 0. MULHU 0xFFFF_FFFF² → 0xFFFF_FFFE.
- DIV −7/2 → −3; REM → −1. stall_o high exactly 33 cycles; result appears on cycle 34; ex_valid 0 in between.
- DIVU x/0 → 0xFFFF_FFFF; REM x/0 → x. DIV 0x8000_0000/−1 → 0x8000_0000; REM → 0.
- flush at DIV cycle 10 → stall_o drops same cycle, no result emitted. Next ADD completes normally. rst_n low mid-divide → all outputs 0.
